// File: rtl/win_disp_pkg.sv
// Shared types and segment encodings for the win-count display.
package win_disp_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_e;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_of(input bcd_digit_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to three BCD digits.
// state     | meaning
// ST_IDLE   | waiting for start_i
// ST_LOAD   | scratch <= {12'b0, bin_i}, iteration count cleared
// ST_SHIFT  | add-3 then shift, 8 iterations; result presented on the last one
// ST_COMMIT | one-cycle tail before accepting the next start
module bin2bcd_seq
  import win_disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [7:0]  bin_i,
  output logic        busy_o,
  output logic [11:0] bcd_o,
  output logic        done_o
);

  conv_state_e state_q, state_d;
  logic [19:0] scratch_q, scratch_d;
  logic [19:0] adj, shifted;
  logic [2:0]  iter_q, iter_d;

  always_comb begin
    adj = scratch_q;
    if (adj[19:16] >= 4'd5) adj[19:16] = adj[19:16] + 4'd3;
    if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;
    if (adj[11:8]  >= 4'd5) adj[11:8]  = adj[11:8]  + 4'd3;
    shifted = adj << 1;
  end

  // Result is handed over with the final shift so the display register
  // updates on the same edge as the eighth iteration.
  assign bcd_o  = shifted[19:8];
  assign done_o = (state_q == ST_SHIFT) && (iter_q == 3'd7);
  assign busy_o = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        scratch_d = {12'b0, bin_i};
        iter_d    = 3'd0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        scratch_d = shifted;
        iter_d    = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      scratch_q <= '0;
      iter_q    <= '0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      iter_q    <= iter_d;
    end
  end

endmodule

// File: rtl/win_display.sv
// Renders the win count and level-up flag on a 4-digit multiplexed
// 7-segment display with leading-zero blanking and a blinking "L".
module win_display
  import win_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wins,
  input  logic       level_up,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] SLOT_LAST = BW'(BLINK_DIV - 1);

  logic [7:0]    wins_q, wins_d, src_q, src_d;
  logic          lu_q, lu_d;
  logic [11:0]   bcd_q, bcd_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [BW-1:0] slot_q, slot_d;
  logic          blink_q, blink_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          busy, done, start, scan_tick;
  logic [11:0]   conv_bcd;

  // src_q holds the value under conversion, so a change mid-conversion
  // still differs from it afterwards and triggers a fresh pass.
  assign start     = !busy && (wins_q != src_q);
  assign scan_tick = (scan_cnt_q == SCAN_LAST);

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .bin_i   (src_q),
    .busy_o  (busy),
    .bcd_o   (conv_bcd),
    .done_o  (done)
  );

  always_comb begin
    wins_d     = wins;
    lu_d       = level_up;
    src_d      = start ? wins_q : src_q;
    bcd_d      = done ? conv_bcd : bcd_q;
    scan_cnt_d = scan_tick ? '0 : scan_cnt_q + SW'(1);
    digit_d    = scan_tick ? digit_q + 2'd1 : digit_q;
    slot_d     = slot_q;
    blink_d    = blink_q;
    if (!lu_q) begin
      slot_d  = '0;
      blink_d = 1'b0;
    end else if (scan_tick) begin
      if (slot_q == SLOT_LAST) begin
        slot_d  = '0;
        blink_d = ~blink_q;
      end else begin
        slot_d = slot_q + BW'(1);
      end
    end
  end

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = 4'hF;
    dp_d  = 1'b1;
    case (digit_q)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = seg_of(bcd_q[3:0]);
        dp_d  = (bcd_q != 12'h255);
      end
      2'd1: begin
        an_d  = 4'b1101;
        seg_d = (bcd_q[11:4] == 8'h00) ? SEG_BLANK : seg_of(bcd_q[7:4]);
      end
      2'd2: begin
        an_d  = 4'b1011;
        seg_d = (bcd_q[11:8] == 4'h0) ? SEG_BLANK : seg_of(bcd_q[11:8]);
      end
      default: begin
        an_d  = 4'b0111;
        seg_d = (lu_q && blink_q) ? SEG_L : SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wins_q     <= '0;
      lu_q       <= 1'b0;
      src_q      <= '0;
      bcd_q      <= '0;
      scan_cnt_q <= '0;
      digit_q    <= '0;
      slot_q     <= '0;
      blink_q    <= 1'b0;
      seg_q      <= SEG_BLANK;
      an_q       <= 4'hF;
      dp_q       <= 1'b1;
    end else begin
      wins_q     <= wins_d;
      lu_q       <= lu_d;
      src_q      <= src_d;
      bcd_q      <= bcd_d;
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      slot_q     <= slot_d;
      blink_q    <= blink_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule
